// File: rtl/openram_march_bist_if.sv
// Shared port-0 bus of the OpenRAM testchip SRAM bank.
//   csb0     : one active-low chip select per macro
//   web0     : 0 = write, 1 = read
//   wmask0   : byte write mask
//   addr0    : shared address
//   din0     : shared write data
//   dout_bus : all macro dout0 ports, macro k at [k*DATA_W +: DATA_W]
// The BIST engine connects through the master modport; the memory side
// connects through the slave modport.
interface openram_march_bist_if #(
   parameter int NUM_SRAMS = 16,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32
);
   logic [NUM_SRAMS-1:0]        csb0;
   logic                        web0;
   logic [DATA_W/8-1:0]         wmask0;
   logic [ADDR_W-1:0]           addr0;
   logic [DATA_W-1:0]           din0;
   logic [NUM_SRAMS*DATA_W-1:0] dout_bus;

   modport master (output csb0, web0, wmask0, addr0, din0, input dout_bus);
   modport slave  (input csb0, web0, wmask0, addr0, din0, output dout_bus);
endinterface

// File: rtl/openram_march_bist.sv
// March C- built-in self-test engine for the OpenRAM testchip SRAM bank.
// Tests one selected macro over addresses 0..addr_max with the sequence
//   E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1); E4 down(r1,w0); E5 up(r0)
// where "0" is the captured pattern and "1" is its complement, and reports
// pass/fail with first-fault capture.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start, abort           begin a test (IDLE only) / cancel a running test
//   stop_on_fail           end the test at the first miscompare
//   sel, addr_max, pattern macro, last address and background, sampled with start
//   sram                   shared port-0 bus (master side)
//   busy, done             test running / one-cycle completion pulse
//   fail, fail_addr/elem/data  sticky fail flag and first-miscompare capture
module openram_march_bist #(
   parameter int NUM_SRAMS = 16,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 32,
   parameter int READ_LAT  = 1,
   localparam int SEL_W    = (NUM_SRAMS > 1) ? $clog2(NUM_SRAMS) : 1,
   localparam int LAT_W    = (READ_LAT > 2) ? $clog2(READ_LAT) : 1
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  stop_on_fail,
   input  logic [SEL_W-1:0]      sel,
   input  logic [ADDR_W-1:0]     addr_max,
   input  logic [DATA_W-1:0]     pattern,
   openram_march_bist_if.master  sram,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [ADDR_W-1:0]     fail_addr,
   output logic [2:0]            fail_elem,
   output logic [DATA_W-1:0]     fail_data
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_WAIT, S_CMP, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [2:0]         elem_q, elem_d;
   logic [ADDR_W-1:0]  addr_q, addr_d, amax_q;
   logic [LAT_W-1:0]   wcnt_q, wcnt_d;
   logic [SEL_W-1:0]   sel_q;
   logic [DATA_W-1:0]  pat_q, din_q, rd_data, exp_data, wr_data;
   logic               accept, bad_sel, miscmp, down, last_addr, adv;

   assign bad_sel   = 32'(sel) >= NUM_SRAMS;
   assign accept    = (state_q == S_IDLE) && start && !abort;
   assign down      = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign last_addr = down ? (addr_q == '0) : (addr_q == amax_q);
   assign rd_data   = sram.dout_bus[sel_q*DATA_W +: DATA_W];
   // E2/E4 read the complement; E1/E3 write the complement
   assign exp_data  = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ~pat_q : pat_q;
   assign wr_data   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ~pat_q : pat_q;
   assign miscmp    = (state_q == S_CMP) && (rd_data != exp_data);

   assign busy = (state_q == S_WR) || (state_q == S_RD) ||
                 (state_q == S_WAIT) || (state_q == S_CMP);
   assign done = (state_q == S_DONE);

   // Bus outputs decode straight from state so an async reset idles the bus at once
   assign sram.csb0   = ((state_q == S_WR) || (state_q == S_RD)) ?
                        ~(NUM_SRAMS'(1) << sel_q) : '1;
   assign sram.web0   = (state_q != S_WR);
   assign sram.wmask0 = '1;
   assign sram.addr0  = addr_q;
   assign sram.din0   = (state_q == S_WR) ? wr_data : din_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      addr_d  = addr_q;
      wcnt_d  = wcnt_q;
      adv     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               elem_d  = 3'd0;
               addr_d  = '0;
               state_d = bad_sel ? S_DONE : S_WR;
            end
         end
         S_WR:   adv = 1'b1;
         S_RD: begin
            wcnt_d  = '0;
            state_d = (READ_LAT > 1) ? S_WAIT : S_CMP;
         end
         S_WAIT: begin
            if (wcnt_q == LAT_W'(READ_LAT - 2)) state_d = S_CMP;
            else                                 wcnt_d  = wcnt_q + 1'b1;
         end
         S_CMP: begin
            if (miscmp && stop_on_fail) state_d = S_DONE;
            else if (elem_q == 3'd5)    adv     = 1'b1;
            else                        state_d = S_WR;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Last operation at this address is finished: step address or element
      if (adv) begin
         if (last_addr) begin
            if (elem_q == 3'd5) begin
               state_d = S_DONE;
            end else begin
               elem_d  = elem_q + 3'd1;
               // E3 and E4 run downward from addr_max
               addr_d  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? amax_q : '0;
               state_d = S_RD;
            end
         end else begin
            addr_d  = down ? (addr_q - 1'b1) : (addr_q + 1'b1);
            state_d = (elem_q == 3'd0) ? S_WR : S_RD;
         end
      end

      if (abort && busy) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         elem_q    <= '0;
         addr_q    <= '0;
         wcnt_q    <= '0;
         amax_q    <= '0;
         sel_q     <= '0;
         pat_q     <= '0;
         din_q     <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_data <= '0;
      end else begin
         elem_q <= elem_d;
         addr_q <= addr_d;
         wcnt_q <= wcnt_d;
         din_q  <= sram.din0;
         if (accept) begin
            sel_q     <= sel;
            amax_q    <= addr_max;
            pat_q     <= pattern;
            fail      <= bad_sel;
            fail_addr <= '0;
            fail_elem <= bad_sel ? 3'd7 : 3'd0;
            fail_data <= '0;
         end else if (miscmp) begin
            fail <= 1'b1;
            if (!fail) begin
               fail_addr <= addr_q;
               fail_elem <= elem_q;
               fail_data <= rd_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_openram_march_bist.sv
module tb_openram_march_bist;

   typedef struct {
      int          cyc;
      logic        fail;
      logic [15:0] faddr;
      logic [2:0]  felem;
      logic [31:0] fdata;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;

   // DUT A: 4 macros, READ_LAT=1
   logic        a_start = 0, a_abort = 0, a_sof = 0;
   logic [1:0]  a_sel = 0;
   logic [15:0] a_amax = 0;
   logic [31:0] a_pat = 0;
   logic        a_busy, a_done, a_fail;
   logic [15:0] a_faddr;
   logic [2:0]  a_felem;
   logic [31:0] a_fdata;
   openram_march_bist_if #(.NUM_SRAMS(4), .ADDR_W(16), .DATA_W(32)) ifA();
   openram_march_bist #(.NUM_SRAMS(4), .ADDR_W(16), .DATA_W(32), .READ_LAT(1)) dutA (
      .clk(clk), .resetn(resetn), .start(a_start), .abort(a_abort), .stop_on_fail(a_sof),
      .sel(a_sel), .addr_max(a_amax), .pattern(a_pat), .sram(ifA),
      .busy(a_busy), .done(a_done), .fail(a_fail), .fail_addr(a_faddr),
      .fail_elem(a_felem), .fail_data(a_fdata));

   // DUT B: 5 macros (so sel=5 is out of range), READ_LAT=2
   logic        b_start = 0, b_abort = 0, b_sof = 0;
   logic [2:0]  b_sel = 0;
   logic [15:0] b_amax = 0;
   logic [31:0] b_pat = 0;
   logic        b_busy, b_done, b_fail;
   logic [15:0] b_faddr;
   logic [2:0]  b_felem;
   logic [31:0] b_fdata;
   openram_march_bist_if #(.NUM_SRAMS(5), .ADDR_W(16), .DATA_W(32)) ifB();
   openram_march_bist #(.NUM_SRAMS(5), .ADDR_W(16), .DATA_W(32), .READ_LAT(2)) dutB (
      .clk(clk), .resetn(resetn), .start(b_start), .abort(b_abort), .stop_on_fail(b_sof),
      .sel(b_sel), .addr_max(b_amax), .pattern(b_pat), .sram(ifB),
      .busy(b_busy), .done(b_done), .fail(b_fail), .fail_addr(b_faddr),
      .fail_elem(b_felem), .fail_data(b_fdata));

   // Memory models; macro 2 address 2 bit 5 optionally stuck at 1 on A
   logic        stuck_en = 0;
   logic [31:0] memA [4][16];
   logic [31:0] rdA  [4];
   logic [31:0] wA;
   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (!ifA.csb0[k]) begin
            if (!ifA.web0) begin
               wA = memA[k][ifA.addr0[3:0]];
               for (int b = 0; b < 4; b++)
                  if (ifA.wmask0[b]) wA[8*b +: 8] = ifA.din0[8*b +: 8];
               memA[k][ifA.addr0[3:0]] <= wA;
            end else begin
               rdA[k] <= memA[k][ifA.addr0[3:0]] |
                         ((stuck_en && k == 2 && ifA.addr0 == 16'd2) ? 32'h20 : 32'h0);
            end
         end
      end
   end
   assign ifA.dout_bus = {rdA[3], rdA[2], rdA[1], rdA[0]};

   logic [31:0] memB [5][16];
   logic [31:0] rdB1 [5];
   logic [31:0] rdB2 [5];
   logic [31:0] wB;
   always @(posedge clk) begin
      for (int k = 0; k < 5; k++) begin
         rdB2[k] <= rdB1[k];
         if (!ifB.csb0[k]) begin
            if (!ifB.web0) begin
               wB = memB[k][ifB.addr0[3:0]];
               for (int b = 0; b < 4; b++)
                  if (ifB.wmask0[b]) wB[8*b +: 8] = ifB.din0[8*b +: 8];
               memB[k][ifB.addr0[3:0]] <= wB;
            end else begin
               rdB1[k] <= memB[k][ifB.addr0[3:0]];
            end
         end
      end
   end
   assign ifB.dout_bus = {rdB2[4], rdB2[3], rdB2[2], rdB2[1], rdB2[0]};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // Scoreboard queues and monitors
   exp_t qA[$], qB[$];
   exp_t eA, eB;
   int bcA = 0, bcB = 0;
   int otherlowA = 0, wr1a2 = 0;
   int n_rdB = 0, gapB = 0, gap_badB = 0;
   bit gap_actB = 0;

   always @(negedge clk) begin
      if (a_busy) bcA++;
      else begin
         if (a_done) begin
            if (qA.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL A_unexpected_done: done=1, required 0");
            end else begin
               eA = qA.pop_front();
               chk("A_busy_cycles", 64'(bcA), 64'(eA.cyc));
               chk("A_fail", 64'(a_fail), 64'(eA.fail));
               chk("A_fail_addr", 64'(a_faddr), 64'(eA.faddr));
               chk("A_fail_elem", 64'(a_felem), 64'(eA.felem));
               chk("A_fail_data", 64'(a_fdata), 64'(eA.fdata));
            end
         end
         bcA = 0;
      end
      if ((ifA.csb0 | 4'b0100) != 4'hF) otherlowA++;
      if (!ifA.csb0[2] && !ifA.web0 && ifA.addr0 == 16'd2 && ifA.din0 == ~a_pat) wr1a2++;
   end

   always @(negedge clk) begin
      if (b_busy) bcB++;
      else begin
         if (b_done) begin
            if (qB.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL B_unexpected_done: done=1, required 0");
            end else begin
               eB = qB.pop_front();
               chk("B_busy_cycles", 64'(bcB), 64'(eB.cyc));
               chk("B_fail", 64'(b_fail), 64'(eB.fail));
               chk("B_fail_addr", 64'(b_faddr), 64'(eB.faddr));
               chk("B_fail_elem", 64'(b_felem), 64'(eB.felem));
               chk("B_fail_data", 64'(b_fdata), 64'(eB.fdata));
            end
         end
         bcB = 0;
      end
      // idle busy cycles between a read and the next access/end must be READ_LAT
      if (gap_actB) begin
         if (b_busy && (&ifB.csb0)) gapB++;
         else begin
            if (gapB != 2) gap_badB++;
            gap_actB = 0;
         end
      end
      if (b_busy && !(&ifB.csb0) && ifB.web0) begin
         n_rdB++;
         gap_actB = 1;
         gapB = 0;
      end
   end

   task automatic start_a(input logic [1:0] s, input logic [15:0] am,
                          input logic [31:0] p, input logic sof);
      @(negedge clk);
      a_sel = s; a_amax = am; a_pat = p; a_sof = sof; a_start = 1;
      @(negedge clk);
      a_start = 0;
   endtask

   task automatic start_b(input logic [2:0] s, input logic [15:0] am,
                          input logic [31:0] p, input logic sof);
      @(negedge clk);
      b_sel = s; b_amax = am; b_pat = p; b_sof = sof; b_start = 1;
      @(negedge clk);
      b_start = 0;
   endtask

   task automatic wait_done(input bit is_b, input string nm);
      bit seen;
      seen = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (is_b ? b_done : a_done) begin seen = 1; break; end
      end
      if (!seen) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_timeout: done=0 after 400 cycles, required 1", nm);
      end
   endtask

   // Wait on A until busy has been observed for n cycles (already counting cur)
   task automatic wait_busy_a(input int n, input int cur, input string nm);
      int c;
      c = cur;
      for (int i = 0; i < 200 && c < n; i++) begin
         @(negedge clk);
         if (a_busy) c++;
      end
      if (c < n) begin
         n_cmp++; n_fail++;
         $display("FAIL %s_timeout: busy count %0d, required %0d", nm, c, n);
      end
   endtask

   task automatic chk_reset_a(input string nm);
      chk({nm, "_csb0"}, 64'(ifA.csb0), 64'hF);
      chk({nm, "_web0"}, 64'(ifA.web0), 64'h1);
      chk({nm, "_wmask0"}, 64'(ifA.wmask0), 64'hF);
      chk({nm, "_addr0"}, 64'(ifA.addr0), 64'h0);
      chk({nm, "_din0"}, 64'(ifA.din0), 64'h0);
      chk({nm, "_busy_done"}, 64'({a_busy, a_done}), 64'h0);
      chk({nm, "_fail_fields"}, {a_fail, a_felem, a_faddr, a_fdata}, 64'h0);
   endtask

   localparam logic [31:0] PAT = 32'hA5A55A5A;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      chk_reset_a("reset");
      chk("reset_B_csb0", 64'(ifB.csb0), 64'h1F);
      @(negedge clk);
      resetn = 1;

      // T1: clean pass, 4 addr x 15 cycles; a start pulse mid-run is ignored
      qA.push_back('{60, 1'b0, 16'h0, 3'd0, 32'h0});
      start_a(2'd2, 16'd3, PAT, 1'b0);
      repeat (20) @(negedge clk);
      a_sel = 2'd0; a_start = 1;
      @(negedge clk);
      a_start = 0; a_sel = 2'd2;
      wait_done(0, "T1");

      // T2: bit5 stuck-at-1 at addr 2, first caught by E1 r0
      stuck_en = 1;
      qA.push_back('{60, 1'b1, 16'd2, 3'd1, 32'hA5A55A7A});
      start_a(2'd2, 16'd3, PAT, 1'b0);
      wait_done(0, "T2");

      // T3: stop at the failing CMP: E0 4 + E1 addr0,1 3+3 + addr2 RD,CMP 2 = 12
      wr1a2 = 0;
      qA.push_back('{12, 1'b1, 16'd2, 3'd1, 32'hA5A55A7A});
      start_a(2'd2, 16'd3, PAT, 1'b1);
      wait_done(0, "T3");
      chk("T3_no_w1_addr2", 64'(wr1a2), 64'h0);
      stuck_en = 0;

      // T4: READ_LAT=2, single address: 1 + 4*4 + 3 = 20 cycles
      qB.push_back('{20, 1'b0, 16'h0, 3'd0, 32'h0});
      start_b(3'd1, 16'd0, 32'h0F0F3C3C, 1'b0);
      wait_done(1, "T4");
      chk("T4_reads", 64'(n_rdB), 64'd5);
      chk("T4_wait_gap_bad", 64'(gap_badB), 64'h0);

      // T5: abort at busy cycle 10, no done afterwards
      start_a(2'd2, 16'd3, PAT, 1'b0);
      wait_busy_a(10, 1, "T5");
      a_abort = 1;
      @(negedge clk);
      a_abort = 0;
      chk("T5_busy_after_abort", 64'(a_busy), 64'h0);
      chk("T5_csb0_after_abort", 64'(ifA.csb0), 64'hF);
      chk("T5_web0_after_abort", 64'(ifA.web0), 64'h1);
      chk("T5_fail_after_abort", 64'(a_fail), 64'h0);
      repeat (70) @(negedge clk);
      // abort wins over a simultaneous start in IDLE
      a_start = 1; a_abort = 1;
      @(negedge clk);
      a_start = 0; a_abort = 0;
      chk("T5_abort_beats_start", 64'({a_busy, a_done}), 64'h0);
      repeat (3) @(negedge clk);
      // out-of-range macro: done the next cycle, no access
      qB.push_back('{0, 1'b1, 16'h0, 3'd7, 32'h0});
      start_b(3'd5, 16'd3, PAT, 1'b0);
      chk("T5_badsel_done_next", 64'(b_done), 64'h1);
      chk("T5_badsel_no_access", 64'(ifB.csb0), 64'h1F);
      repeat (3) @(negedge clk);

      // T6: async reset during E3 (E3 spans busy cycles 29..40)
      start_a(2'd2, 16'd3, PAT, 1'b0);
      wait_busy_a(33, 1, "T6");
      #2 resetn = 0;
      #1 chk_reset_a("T6_async");
      @(negedge clk);
      resetn = 1;
      qA.push_back('{60, 1'b0, 16'h0, 3'd0, 32'h0});
      start_a(2'd2, 16'd3, 32'h3C3CC3C3, 1'b0);
      wait_done(0, "T6_restart");

      repeat (5) @(negedge clk);
      chk("A_other_csb_low", 64'(otherlowA), 64'h0);
      chk("A_pending_expected", 64'(qA.size()), 64'h0);
      chk("B_pending_expected", 64'(qB.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
